// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI word slave.
package spi_pkg;

    localparam int WORD_COUNT_W = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Data is sampled on the rising sclk edge when CPOL and CPHA agree.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    // Shift the pin value through the chain; reset parks it at the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {DEPTH{RST_VAL}};
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_word_slave.sv
// SPI slave that assembles WIDTH-bit words, oversampling sclk/ss_n/mosi on clk.
// Define SPI_WORD_SLAVE_MISO_EN to build the transmit path (miso, tx_data/tx_load,
// tx_ready); without it miso and tx_ready are tied low.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | slave not selected, sclk ignored, outputs held
// ST_ACTIVE | slave selected, shifting bits on sclk edges
module spi_word_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sclk,
    input  logic                    ss_n,
    input  logic                    mosi,
    output logic                    miso,
    output logic [WIDTH-1:0]        rx_data,
    output logic                    rx_valid,
    output logic                    sot,
    output logic                    eot,
    output logic                    frame_err,
    output logic [WORD_COUNT_W-1:0] word_count,
    input  logic [WIDTH-1:0]        tx_data,
    input  logic                    tx_load,
    output logic                    tx_ready
);

    localparam int               CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam logic             SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic sclk_s, ss_n_s, mosi_s;
    logic sclk_d, ss_d;
    logic [1:0] settle_cnt;
    logic armed;
    logic sclk_rise, sclk_fall, sample_edge, shift_edge;
    logic ss_fall, ss_rise;
    state_t state, state_next;
    logic frame_start, frame_end;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic first_word;
    logic word_done;
    logic last_sample;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(ss_n), .q(ss_n_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
    );

    // Edge history; armed only once the flushed synchroniser shows ss_n high, so a
    // select held low across reset release cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d     <= 1'(CPOL);
            ss_d       <= 1'b1;
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            ss_d   <= ss_n_s;
            if (settle_cnt != 2'(SYNC_STAGES)) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
            if (settle_cnt == 2'(SYNC_STAGES) && ss_n_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign ss_fall     = ss_d & ~ss_n_s & armed;
    assign ss_rise     = ~ss_d & ss_n_s;
    assign last_sample = (state == ST_ACTIVE) && sample_edge && (bit_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic with frame start/end strobes.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_next  = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_next = ST_IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Receive datapath: shift on sample edges, publish the word one cycle after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            first_word <= 1'b0;
            word_done  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            sot        <= 1'b0;
            eot        <= 1'b0;
            frame_err  <= 1'b0;
            word_count <= '0;
        end else begin
            rx_valid  <= 1'b0;
            sot       <= 1'b0;
            eot       <= 1'b0;
            frame_err <= 1'b0;
            word_done <= 1'b0;
            if (frame_start) begin
                bit_cnt    <= '0;
                word_count <= '0;
                first_word <= 1'b1;
                rx_shift   <= '0;
            end else if (frame_end) begin
                eot       <= 1'b1;
                frame_err <= (bit_cnt != '0);
                bit_cnt   <= '0;
                rx_shift  <= '0;
            end else if (state == ST_ACTIVE && sample_edge) begin
                if (MSB_FIRST != 0) begin
                    rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                end else begin
                    rx_shift <= {mosi_s, rx_shift[WIDTH-1:1]};
                end
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (word_done) begin
                rx_data    <= rx_shift;
                rx_valid   <= 1'b1;
                sot        <= first_word;
                first_word <= 1'b0;
                if (word_count != {WORD_COUNT_W{1'b1}}) begin
                    word_count <= word_count + 1'b1;
                end
            end
        end
    end

`ifdef SPI_WORD_SLAVE_MISO_EN
    logic [WIDTH-1:0] tx_hold, tx_shift, next_word;
    logic             tx_ready_q, miso_q;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // An empty holding register feeds zeros into the shifter.
    assign next_word = tx_ready_q ? '0 : tx_hold;

    // Transmit path: reload at frame start and word boundaries, drive miso on shift edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_hold    <= '0;
            tx_shift   <= '0;
            tx_ready_q <= 1'b1;
            miso_q     <= 1'b0;
        end else begin
            if (frame_start || last_sample) begin
                tx_ready_q <= 1'b1;
                if (frame_start && CPHA == 0) begin
                    miso_q   <= head_bit(next_word);
                    tx_shift <= advance(next_word);
                end else begin
                    tx_shift <= next_word;
                end
            end else if (state == ST_ACTIVE && shift_edge && !frame_end) begin
                miso_q   <= head_bit(tx_shift);
                tx_shift <= advance(tx_shift);
            end
            if (frame_end) begin
                miso_q <= 1'b0;
            end
            if (tx_load && tx_ready_q) begin
                tx_hold    <= tx_data;
                tx_ready_q <= 1'b0;
            end
        end
    end

    assign miso     = miso_q;
    assign tx_ready = tx_ready_q;
`else
    logic unused_tx;
    assign unused_tx = ^{tx_data, tx_load, last_sample};
    assign miso      = 1'b0;
    assign tx_ready  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_slave.sv
// Scoreboard bench for spi_word_slave: five instances cover the SPI modes and bit orders.
module tb_spi_word_slave;

    localparam int N = 5;
    localparam int H = 8;
    localparam int S = 2;
    localparam logic TX_EN =
`ifdef SPI_WORD_SLAVE_MISO_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        int          inst;
        bit          is_eot;
        logic [31:0] data;
        bit          sot;
        bit          ferr;
        int          wc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] sclk_pin, ss_pin, mosi_pin, tx_ld;
    logic [N-1:0] miso_v, rxv, sotv, eotv, ferrv, txrdy;
    logic [31:0] tx_word;
    logic [31:0] rxd [N];
    logic [15:0] wcv [N];
    time last_sample_t [N];
    logic [31:0] miso_bits;
    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int W  = (g == 0) ? 8 : 16;
            localparam int CP = (g == 2 || g == 3) ? 1 : 0;
            localparam int CH = (g == 1 || g == 3) ? 1 : 0;
            localparam int MF = (g == 4) ? 0 : 1;
            logic [W-1:0] rx_data_w;
            logic [15:0]  wc_w;
            spi_word_slave #(
                .WIDTH(W), .CPOL(CP), .CPHA(CH), .MSB_FIRST(MF), .SYNC_STAGES(S)
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .sclk(sclk_pin[g]), .ss_n(ss_pin[g]),
                .mosi(mosi_pin[g]), .miso(miso_v[g]), .rx_data(rx_data_w),
                .rx_valid(rxv[g]), .sot(sotv[g]), .eot(eotv[g]), .frame_err(ferrv[g]),
                .word_count(wc_w), .tx_data(tx_word[W-1:0]), .tx_load(tx_ld[g]),
                .tx_ready(txrdy[g])
            );
            assign rxd[g] = 32'(rx_data_w);
            assign wcv[g] = wc_w;
        end
    endgenerate

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_rx(input int inst, input logic [31:0] data, input bit s, input int wc);
        exp_t e;
        e.inst = inst; e.is_eot = 1'b0; e.data = data; e.sot = s; e.ferr = 1'b0; e.wc = wc;
        exp_q.push_back(e);
    endtask

    task automatic push_eot(input int inst, input bit ferr, input int wc);
        exp_t e;
        e.inst = inst; e.is_eot = 1'b1; e.data = '0; e.sot = 1'b0; e.ferr = ferr; e.wc = wc;
        exp_q.push_back(e);
    endtask

    task automatic take(input int i, input bit is_eot);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: inst %0d eot=%0d seen, expected none at %0t", i, is_eot, $time);
            return;
        end
        e = exp_q.pop_front();
        check32("event_inst", i, e.inst);
        check32("event_kind", 32'(is_eot), 32'(e.is_eot));
        if (!is_eot) begin
            check32("rx_data", rxd[i], e.data);
            check32("sot", 32'(sotv[i]), 32'(e.sot));
            check32("rx_latency", 32'(($time - last_sample_t[i]) / 10), S + 2);
        end else begin
            check32("frame_err", 32'(ferrv[i]), 32'(e.ferr));
        end
        check32("word_count", 32'(wcv[i]), e.wc);
    endtask

    // Monitor: every rx_valid or eot pulse consumes one expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (rxv[i]) take(i, 1'b0);
                if (eotv[i]) take(i, 1'b1);
            end
        end
    end

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    task automatic ss_begin(input int i);
        @(negedge clk);
        ss_pin[i] = 1'b0;
        wait_h();
    endtask

    task automatic ss_end(input int i);
        wait_h();
        ss_pin[i] = 1'b1;
        repeat (4) wait_h();
    endtask

    task automatic send_bits(input int i, input logic cpol, input logic cpha,
                             input logic [31:0] data, input int width, input int nbits);
        logic bv;
        for (int b = 0; b < nbits; b++) begin
            bv = data[width-1-b];
            if (!cpha) begin
                mosi_pin[i] = bv;
                wait_h();
                miso_bits = {miso_bits[30:0], miso_v[i]};
                sclk_pin[i] = ~cpol;
                last_sample_t[i] = $time;
                wait_h();
                sclk_pin[i] = cpol;
            end else begin
                sclk_pin[i] = ~cpol;
                mosi_pin[i] = bv;
                wait_h();
                miso_bits = {miso_bits[30:0], miso_v[i]};
                sclk_pin[i] = cpol;
                last_sample_t[i] = $time;
                wait_h();
            end
        end
    endtask

    initial begin
        logic [31:0] exp_word;
        logic        cpol, cpha;
        sclk_pin  = 5'b01100;
        ss_pin    = '1;
        mosi_pin  = '0;
        tx_ld     = '0;
        tx_word   = '0;
        miso_bits = '0;
        for (int i = 0; i < N; i++) last_sample_t[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check32("reset_rx_data", rxd[0], 32'h0);
        check32("reset_word_count", 32'(wcv[0]), 32'h0);
        check32("reset_miso", 32'(miso_v[0]), 32'h0);
        check32("reset_tx_ready", 32'(txrdy[0]), 32'(TX_EN));

        // Mode 0, two-word frame with a transmit word preloaded.
        @(negedge clk);
        tx_word  = 32'hC3;
        tx_ld[0] = 1'b1;
        @(negedge clk);
        tx_ld[0] = 1'b0;
        check32("tx_ready_after_load", 32'(txrdy[0]), 32'h0);
        push_rx(0, 32'hA5, 1'b1, 1);
        push_rx(0, 32'h3C, 1'b0, 2);
        push_eot(0, 1'b0, 2);
        ss_begin(0);
        check32("tx_ready_frame_start", 32'(txrdy[0]), 32'(TX_EN));
        miso_bits = '0;
        send_bits(0, 1'b0, 1'b0, 32'hA5, 8, 8);
        check32("miso_word1", miso_bits & 32'hFF, TX_EN ? 32'hC3 : 32'h0);
        check32("tx_ready_word1_end", 32'(txrdy[0]), 32'(TX_EN));
        send_bits(0, 1'b0, 1'b0, 32'h3C, 8, 8);
        check32("miso_word2_zero", miso_bits & 32'hFF, 32'h0);
        ss_end(0);
        check32("miso_idle", 32'(miso_v[0]), 32'h0);

        // Modes 1..3 MSB first, then mode 0 LSB first, 16-bit word 0x1234.
        for (int k = 1; k < N; k++) begin
            cpol = (k == 2 || k == 3);
            cpha = (k == 1 || k == 3);
            exp_word = (k == 4) ? 32'h2C48 : 32'h1234;
            push_rx(k, exp_word, 1'b1, 1);
            push_eot(k, 1'b0, 1);
            ss_begin(k);
            send_bits(k, cpol, cpha, 32'h1234, 16, 16);
            ss_end(k);
            check32("rx_data_hold_idle", rxd[k], exp_word);
        end

        // Frame aborted after 5 of 8 bits.
        push_eot(0, 1'b1, 0);
        ss_begin(0);
        send_bits(0, 1'b0, 1'b0, 32'h5A, 8, 5);
        ss_end(0);
        check32("partial_rx_data_hold", rxd[0], 32'h3C);
        check32("partial_word_count", 32'(wcv[0]), 32'h0);

        // Reset mid-word with select held low across release.
        ss_begin(0);
        send_bits(0, 1'b0, 1'b0, 32'hF0, 8, 3);
        rst_n = 1'b0;
        #1;
        check32("midreset_rx_data", rxd[0], 32'h0);
        check32("midreset_word_count", 32'(wcv[0]), 32'h0);
        check32("midreset_rx_valid", 32'(rxv[0]), 32'h0);
        check32("midreset_eot", 32'(eotv[0]), 32'h0);
        check32("midreset_miso", 32'(miso_v[0]), 32'h0);
        check32("midreset_tx_ready", 32'(txrdy[0]), 32'(TX_EN));
        check32("midreset_other_rx_data", rxd[1], 32'h0);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        mosi_pin[0] = 1'b0;
        ss_end(0);
        push_rx(0, 32'h96, 1'b1, 1);
        push_eot(0, 1'b0, 1);
        ss_begin(0);
        send_bits(0, 1'b0, 1'b0, 32'h96, 8, 8);
        ss_end(0);

        repeat (20) @(negedge clk);
        check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_word_slave.md
SPI_WORD_SLAVE -- requirements
Module: spi_word_slave

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the word length in bits; legal range 4..32.
REQ-002 Parameter CPOL, default 0, SHALL set the sclk idle level.
REQ-003 Parameter CPHA, default 0: 0 SHALL sample on the leading edge; 1 SHALL sample on the trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 SHALL shift MSB first; 0 SHALL shift LSB first.
REQ-005 Parameter SYNC_STAGES, default 2, SHALL set the synchroniser depth on sclk, ss_n and mosi; legal range 2..3.
REQ-006 Port clk, input, 1 bit: the single system clock. All logic SHALL be clocked on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port sclk, input, 1 bit: SPI clock, asynchronous to clk.
REQ-009 Port ss_n, input, 1 bit: slave select, active-low.
REQ-010 Port mosi, input, 1 bit: serial data from master.
REQ-011 Port miso, output, 1 bit: serial data to master.
REQ-012 Port rx_data, output, WIDTH bits: last complete received word.
REQ-013 Port rx_valid, output, 1 bit: one-cycle pulse; rx_data is new.
REQ-014 Port sot, output, 1 bit: asserted with rx_valid on the first word of a frame.
REQ-015 Port eot, output, 1 bit: one-cycle pulse on frame end.
REQ-016 Port frame_err, output, 1 bit: asserted with eot when the frame ended mid-word.
REQ-017 Port word_count, output, 16 bits: complete words received in the current or last frame.
REQ-018 Port tx_data, input, WIDTH bits: next word to transmit.
REQ-019 Port tx_load, input, 1 bit: write strobe for tx_data.
REQ-020 Port tx_ready, output, 1 bit: the transmit holding register is empty.

Function
REQ-021 sclk, ss_n and mosi SHALL each pass through SYNC_STAGES flops before any use; edges SHALL be detected on the synchronised sclk.
REQ-022 FSM states SHALL be IDLE and ACTIVE.
- IDLE->ACTIVE on synchronised ss_n 1->0.
- ACTIVE->IDLE on synchronised ss_n 0->1.
REQ-023 On entry to ACTIVE: bit counter=0, word_count=0, first-word flag=1, rx shift register=0.
REQ-024 In ACTIVE, each sample edge SHALL shift the synchronised mosi in and increment the bit counter.
- Sample edge is rising when CPOL==CPHA, otherwise falling.
REQ-025 On the sample edge carrying bit WIDTH-1, the next cycle SHALL:
- load rx_data;
- pulse rx_valid;
- pulse sot if the first-word flag is set, then clear the flag;
- increment word_count, saturating at 16'hFFFF;
- wrap the bit counter to 0.
REQ-026 rx_valid SHALL rise exactly SYNC_STAGES+2 clk cycles after the sclk pin sample edge.
REQ-027 On ACTIVE->IDLE, eot SHALL pulse once; frame_err SHALL equal (bit counter != 0) in the same cycle, and partial bits SHALL be discarded.
REQ-028 sclk edges SHALL be ignored in IDLE; rx_data and word_count SHALL hold their values in IDLE.
REQ-029 The design SHALL be correct for clk frequency >= 4x sclk frequency; behaviour below that is unspecified.

Transmit path
REQ-030 tx_load while tx_ready=1 SHALL capture tx_data and clear tx_ready next cycle; tx_load while tx_ready=0 SHALL be ignored.
REQ-031 At frame start and after each completed word, the holding register SHALL move to the tx shift register and set tx_ready. If the holding register is empty, all-zeros SHALL be shifted.
REQ-032 miso SHALL update on shift edges (the edge opposite the sample edge). With CPHA=0, the first bit SHALL be driven on ACTIVE entry.
REQ-033 miso SHALL be 0 in IDLE.

Reset
REQ-034 rst_n low SHALL asynchronously force:
- FSM to IDLE;
- all synchronisers to their inactive values (sclk=CPOL, ss_n=1, mosi=0);
- rx_data, word_count, rx_valid, sot, eot, frame_err, miso to 0;
- tx_ready to 1.
REQ-035 Reset assertion mid-frame SHALL abort the frame with no eot.
REQ-036 After release, a frame SHALL start only on a fresh ss_n falling edge.

Configuration
REQ-037 Macro SPI_WORD_SLAVE_MISO_EN defined SHALL compile in the transmit path (REQ-030..033).
REQ-038 With SPI_WORD_SLAVE_MISO_EN undefined:
- miso SHALL be tied 0 and tx_ready tied 0;
- tx_data and tx_load SHALL be ignored;
- receive behaviour SHALL be identical.

Structure
REQ-039 A shared package spi_pkg SHALL hold the FSM state typedef, the sample-edge select function of (CPOL, CPHA), and constant WORD_COUNT_W=16.
REQ-040 The synchroniser SHALL be a sub-module sync_ff (parametrised depth, reset value) instantiated three times.

Verification
REQ-041 Mode 0, WIDTH=8: frame with 0xA5, 0x3C -> rx_valid x2, sot on the first word only, rx_data 0xA5 then 0x3C, eot once, frame_err=0, word_count=2.
REQ-042 Modes 1, 2 and 3, WIDTH=16, word 0x1234 -> rx_data=0x1234 in each mode; MSB_FIRST=0 -> 0x2C48.
REQ-043 ss_n deasserted after 5 of 8 bits -> no rx_valid, eot=1 with frame_err=1, word_count=0.
REQ-044 MISO_EN, tx_load 0xC3 before frame, mode 0 -> miso bit stream 1,1,0,0,0,0,1,1; second word with no load -> zeros; tx_ready rises after each word boundary.
REQ-045 rst_n pulsed low mid-word -> outputs at reset values immediately; no eot; the next full frame is received correctly.
